// File: rtl/multiciclo_seq.sv
// -----------------------------------------------------------------------------
// multiciclo_seq
//
// Control sequencer for a multicycle processor. Every instruction walks
// IF -> ID -> EX -> [WAIT_EX] -> MEM -> WB -> [WAIT_WB] -> SUMPC. Each phase
// raises a one-cycle enable strobe for the datapath. A zero instruction word
// seen in ID halts the sequencer in FIM until reset. SUMPC counts retired
// instructions.
//
// Optional feature (compile-time macro MULTICICLO_STEP_EN):
//   defined   : run_mode selects free run (1) or single-step (0). In single-step
//               mode SUMPC parks in PAUSE until a rising edge of step is seen.
//   undefined : PAUSE is never entered, SUMPC always returns to IF, and
//               run_mode/step are ignored.
//
// Parameters
//   EX_WAIT   : idle cycles between EX and MEM (0..15)
//   WB_WAIT   : idle cycles between WB and SUMPC (0..15)
//   CNT_WIDTH : width of the retired-instruction counter
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous reset, active low
//   instrucao  in   32-bit instruction word, meaningful from ID onward
//   run_mode   in   1 = free run, 0 = single-step (MULTICICLO_STEP_EN only)
//   step       in   single-step request (MULTICICLO_STEP_EN only)
//   estado     out  current state code (also the FSM debug view)
//   fetch_en   out  high during IF
//   decode_en  out  high during ID
//   ex_en      out  high during EX
//   mem_en     out  high during MEM
//   wb_en      out  high during WB
//   pc_en      out  high during SUMPC
//   halted     out  high during FIM
//   retired    out  count of completed non-zero instructions (wraps)
//
// Handshake: there is no valid/ready pair on this block. Each *_en strobe is
// a one-cycle, registered qualifier that is high exactly while estado holds
// the matching state; consumers sample it on the rising clock edge.
// -----------------------------------------------------------------------------
module multiciclo_seq #(
  parameter int unsigned EX_WAIT   = 2,
  parameter int unsigned WB_WAIT   = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instrucao,
  input  logic                 run_mode,
  input  logic                 step,
  output logic [3:0]           estado,
  output logic                 fetch_en,
  output logic                 decode_en,
  output logic                 ex_en,
  output logic                 mem_en,
  output logic                 wb_en,
  output logic                 pc_en,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    S_IF      = 4'b0000,
    S_ID      = 4'b0001,
    S_EX      = 4'b0010,
    S_MEM     = 4'b0011,
    S_WB      = 4'b0100,
    S_WAIT_EX = 4'b0101,
    S_WAIT_WB = 4'b0110,
    S_SUMPC   = 4'b1000,
    S_FIM     = 4'b1001,
    S_PAUSE   = 4'b1010
  } state_t;

  // The shared wait counter is loaded with (wait - 1) on entry to a wait
  // state and the state is left when it reads zero, so a wait state lasts
  // exactly EX_WAIT / WB_WAIT cycles. The load values only matter when the
  // corresponding wait is non-zero.
  localparam logic [3:0] EX_LOAD = (EX_WAIT > 0) ? 4'(EX_WAIT - 1) : 4'd0;
  localparam logic [3:0] WB_LOAD = (WB_WAIT > 0) ? 4'(WB_WAIT - 1) : 4'd0;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           w_wait_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_fetch_en;
  logic                 r_decode_en;
  logic                 r_ex_en;
  logic                 r_mem_en;
  logic                 r_wb_en;
  logic                 r_pc_en;
  logic                 r_halted;
  logic                 w_resume;

`ifdef MULTICICLO_STEP_EN
  // Previous value of step. A release needs step high now and low on the
  // previous cycle, so holding step high lets only one instruction through.
  // The register runs in every state, which is what keeps an edge seen
  // outside PAUSE from being remembered: by the time PAUSE is reached the
  // register already holds the high level.
  logic r_step_d;
  logic w_step_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  assign w_step_rise = step & ~r_step_d;
  assign w_resume    = run_mode;
`else
  // Free run only: the mode and step inputs have no effect on this build.
  logic w_unused_inputs;
  assign w_unused_inputs = run_mode ^ step;
  assign w_resume        = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // State register and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IF;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next         = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IF: begin
        w_next = S_ID;
      end
      S_ID: begin
        // An all-zero word is the program terminator.
        if (instrucao == 32'd0) begin
          w_next = S_FIM;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        if (EX_WAIT > 0) begin
          w_next         = S_WAIT_EX;
          w_wait_cnt_nxt = EX_LOAD;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WAIT_EX: begin
        if (r_wait_cnt == 4'd0) begin
          w_next = S_MEM;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      S_MEM: begin
        w_next = S_WB;
      end
      S_WB: begin
        if (WB_WAIT > 0) begin
          w_next         = S_WAIT_WB;
          w_wait_cnt_nxt = WB_LOAD;
        end else begin
          w_next = S_SUMPC;
        end
      end
      S_WAIT_WB: begin
        if (r_wait_cnt == 4'd0) begin
          w_next = S_SUMPC;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      S_SUMPC: begin
        // run_mode is looked at only here, at the instruction boundary.
        if (w_resume) begin
          w_next = S_IF;
        end else begin
          w_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
`ifdef MULTICICLO_STEP_EN
        if (w_step_rise) begin
          w_next = S_IF;
        end
`else
        // Unreachable on this build; recover to IF if it is ever seen.
        w_next = S_IF;
`endif
      end
      S_FIM: begin
        w_next = S_FIM;
      end
      default: begin
        w_next = S_IF;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered strobes: decoded from the next state and registered, so each
  // strobe is a flop output that is high exactly while r_state holds its
  // state, with no combinational path from the inputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_en  <= 1'b1;
      r_decode_en <= 1'b0;
      r_ex_en     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_wb_en     <= 1'b0;
      r_pc_en     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_fetch_en  <= (w_next == S_IF);
      r_decode_en <= (w_next == S_ID);
      r_ex_en     <= (w_next == S_EX);
      r_mem_en    <= (w_next == S_MEM);
      r_wb_en     <= (w_next == S_WB);
      r_pc_en     <= (w_next == S_SUMPC);
      r_halted    <= (w_next == S_FIM);
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter: one count per SUMPC, wraps naturally.
  // Zero instructions never reach SUMPC, so they are not counted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= '0;
    end else if (r_state == S_SUMPC) begin
      r_retired <= r_retired + CNT_WIDTH'(1);
    end
  end

  assign estado    = r_state;
  assign fetch_en  = r_fetch_en;
  assign decode_en = r_decode_en;
  assign ex_en     = r_ex_en;
  assign mem_en    = r_mem_en;
  assign wb_en     = r_wb_en;
  assign pc_en     = r_pc_en;
  assign halted    = r_halted;
  assign retired   = r_retired;

endmodule

// File: tb/tb_multiciclo_seq.sv
// -----------------------------------------------------------------------------
// tb_multiciclo_seq
//
// Three sequencer instances share one clock:
//   dut0 : default timing (EX_WAIT=2, WB_WAIT=3, 16-bit counter)
//   dut1 : EX_WAIT=0, WB_WAIT=0
//   dut2 : default timing, CNT_WIDTH=2
// The main process issues directed stimulus and pushes hand-computed
// expectations into queues; one monitor per instance pops and compares when
// the instance presents an event (fetch_en pulse, retirement, state trace).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multiciclo_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] INSTR = 32'h0050_0093;

  // dut0
  logic        rst0, run0, step0;
  logic [31:0] instr0;
  logic [3:0]  est0;
  logic        f0, d0, e0, m0, w0, p0, h0;
  logic [15:0] ret0;
  // dut1
  logic        rst1;
  logic [31:0] instr1;
  logic [3:0]  est1;
  logic        f1, d1, e1, m1, w1, p1, h1;
  logic [15:0] ret1;
  // dut2
  logic        rst2;
  logic [31:0] instr2;
  logic [3:0]  est2;
  logic        f2, d2, e2, m2, w2, p2, h2;
  logic [1:0]  ret2;

  multiciclo_seq dut0 (
    .clk(clk), .rst(rst0), .instrucao(instr0), .run_mode(run0), .step(step0),
    .estado(est0), .fetch_en(f0), .decode_en(d0), .ex_en(e0), .mem_en(m0),
    .wb_en(w0), .pc_en(p0), .halted(h0), .retired(ret0)
  );

  multiciclo_seq #(.EX_WAIT(0), .WB_WAIT(0)) dut1 (
    .clk(clk), .rst(rst1), .instrucao(instr1), .run_mode(1'b1), .step(1'b0),
    .estado(est1), .fetch_en(f1), .decode_en(d1), .ex_en(e1), .mem_en(m1),
    .wb_en(w1), .pc_en(p1), .halted(h1), .retired(ret1)
  );

  multiciclo_seq #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .instrucao(instr2), .run_mode(1'b1), .step(1'b0),
    .estado(est2), .fetch_en(f2), .decode_en(d2), .ex_en(e2), .mem_en(m2),
    .wb_en(w2), .pc_en(p2), .halted(h2), .retired(ret2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  logic [15:0] per0_q[$];   // expected fetch-to-fetch periods, dut0
  logic [15:0] ret0_q[$];   // expected retired value after each SUMPC, dut0
  logic [15:0] per1_q[$];
  logic [3:0]  trace1_q[$]; // expected estado, one entry per cycle, dut1
  logic [1:0]  ret2_q[$];
  int          wait_seen1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next falling edge: outputs are stable there
  // and the monitors have already consumed this edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  initial begin : mon0
    int   cyc;
    int   last_f;
    bit   have_f;
    bit   prev_p;
    logic [15:0] exp_v;
    cyc = 0; last_f = 0; have_f = 0; prev_p = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst0) begin
        have_f = 0;
        prev_p = 0;
      end else begin
        if (prev_p && ret0_q.size() > 0) begin
          exp_v = ret0_q.pop_front();
          check("retired0", 32'(ret0), 32'(exp_v));
        end
        prev_p = p0;
        if (f0) begin
          if (have_f && per0_q.size() > 0) begin
            exp_v = per0_q.pop_front();
            check("period0", 32'(cyc - last_f), 32'(exp_v));
          end
          last_f = cyc;
          have_f = 1;
        end
      end
    end
  end

  initial begin : mon1
    int   cyc;
    int   last_f;
    bit   have_f;
    logic [15:0] exp_p;
    logic [3:0]  exp_s;
    cyc = 0; last_f = 0; have_f = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst1) begin
        have_f = 0;
      end else begin
        if (trace1_q.size() > 0) begin
          exp_s = trace1_q.pop_front();
          check("trace1", 32'(est1), 32'(exp_s));
        end
        if (est1 == 4'b0101 || est1 == 4'b0110) wait_seen1++;
        if (f1) begin
          if (have_f && per1_q.size() > 0) begin
            exp_p = per1_q.pop_front();
            check("period1", 32'(cyc - last_f), 32'(exp_p));
          end
          last_f = cyc;
          have_f = 1;
        end
      end
    end
  end

  initial begin : mon2
    bit         prev_p;
    logic [1:0] exp_v;
    prev_p = 0;
    forever begin
      @(negedge clk);
      if (!rst2) begin
        prev_p = 0;
      end else begin
        if (prev_p && ret2_q.size() > 0) begin
          exp_v = ret2_q.pop_front();
          check("retired2", 32'(ret2), 32'(exp_v));
        end
        prev_p = p2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / directed stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    int bad;
    int fcount;
    int guard;

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    instr0 = INSTR; instr1 = INSTR; instr2 = INSTR;
    run0 = 1'b1; step0 = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_estado", 32'(est0), 32'h0);
    check("rst_fetch_en", 32'(f0), 32'h1);
    check("rst_other_strobes", 32'({d0, e0, m0, w0, p0}), 32'h0);
    check("rst_halted", 32'(h0), 32'h0);
    check("rst_retired", 32'(ret0), 32'h0);

    // Free run: 11-cycle instruction period, retired counts up.
    // The IF right after release is not seen by the monitor (reset was
    // still low at that falling edge), so fetches 2..6 give 4 periods.
    for (int i = 0; i < 4; i++) per0_q.push_back(16'd11);
    for (int i = 1; i <= 5; i++) ret0_q.push_back(16'(i));
    rst0 = 1'b1;
    tick();
    check("release_to_id", 32'(est0), 32'h1);

    guard = 0;
    while (!(ret0 == 16'd5 && est0 == 4'b0110) && guard < 200) begin
      tick();
      guard++;
    end
    check("reach_wait_wb_ret5", 32'(guard < 200), 32'h1);
    check("period0_queue_drained", 32'(per0_q.size()), 32'h0);
    check("ret0_queue_drained", 32'(ret0_q.size()), 32'h0);

    // Asynchronous reset in WAIT_WB: takes effect with no clock edge.
    rst0 = 1'b0;
    #1;
    check("async_estado", 32'(est0), 32'h0);
    check("async_retired", 32'(ret0), 32'h0);
    check("async_fetch_en", 32'(f0), 32'h1);
    check("async_strobes", 32'({d0, e0, m0, w0, p0, h0}), 32'h0);

    // One instruction, then a zero word: halt.
    ret0_q.push_back(16'd1);
    tick();
    rst0 = 1'b1;
    tick();
    check("rerelease_to_id", 32'(est0), 32'h1);
    guard = 0;
    while (!(f0 && ret0 == 16'd1) && guard < 40) begin
      tick();
      guard++;
    end
    check("second_fetch_seen", 32'(guard < 40), 32'h1);
    instr0 = 32'h0;
    tick();
    check("zero_instr_id", 32'(est0), 32'h1);
    tick();
    check("fim_estado", 32'(est0), 32'h9);
    check("fim_halted", 32'(h0), 32'h1);
    check("fim_strobes", 32'({f0, d0, e0, m0, w0, p0}), 32'h0);
    bad = 0;
    repeat (50) begin
      tick();
      if (est0 != 4'b1001 || ret0 != 16'd1 || h0 != 1'b1 || {f0, d0, e0, m0, w0, p0} != 6'd0) bad++;
    end
    check("fim_hold_50_bad_cycles", 32'(bad), 32'h0);
    check("fim_retired", 32'(ret0), 32'h1);

`ifdef MULTICICLO_STEP_EN
    // Single-step mode.
    rst0 = 1'b0; instr0 = INSTR; run0 = 1'b0; step0 = 1'b0;
    tick(); tick();
    ret0_q.push_back(16'd1);
    ret0_q.push_back(16'd2);
    rst0 = 1'b1;
    guard = 0;
    while (est0 != 4'b1010 && guard < 40) begin
      tick();
      guard++;
    end
    check("pause_reached", 32'(est0), 32'ha);
    check("pause_latency", 32'(guard), 32'd11);
    bad = 0;
    repeat (3) begin
      tick();
      if (est0 != 4'b1010) bad++;
    end
    check("pause_hold_bad_cycles", 32'(bad), 32'h0);

    // step held high for 20 cycles releases exactly one instruction.
    step0 = 1'b1;
    fcount = 0;
    repeat (20) begin
      tick();
      if (f0) fcount++;
    end
    check("held_step_fetches", 32'(fcount), 32'h1);
    check("held_step_back_in_pause", 32'(est0), 32'ha);
    step0 = 1'b0;
    tick(); tick();
    check("step_low_stays_pause", 32'(est0), 32'ha);

    // Second rising edge releases the next instruction; an edge during it
    // must not be remembered.
    step0 = 1'b1;
    tick();
    check("step2_to_if", 32'(est0), 32'h0);
    step0 = 1'b0;
    tick(); tick();
    step0 = 1'b1;
    tick();
    step0 = 1'b0;
    guard = 0;
    while (est0 != 4'b1010 && guard < 40) begin
      tick();
      guard++;
    end
    check("pause_after_step2", 32'(est0), 32'ha);
    bad = 0;
    repeat (5) begin
      tick();
      if (est0 != 4'b1010) bad++;
    end
    check("no_queued_step_bad_cycles", 32'(bad), 32'h0);
    check("step_ret_queue_drained", 32'(ret0_q.size()), 32'h0);
`else
    // Without the step feature run_mode=0 and step activity change nothing.
    rst0 = 1'b0; instr0 = INSTR; run0 = 1'b0; step0 = 1'b0;
    tick(); tick();
    per0_q.push_back(16'd11);
    per0_q.push_back(16'd11);
    ret0_q.push_back(16'd1);
    ret0_q.push_back(16'd2);
    rst0 = 1'b1;
    bad = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      step0 = ((i % 3) == 0);
      if (est0 == 4'b1010) bad++;
    end
    step0 = 1'b0;
    check("never_pause_bad_cycles", 32'(bad), 32'h0);
    check("freerun_period_queue_drained", 32'(per0_q.size()), 32'h0);
    check("freerun_ret_queue_drained", 32'(ret0_q.size()), 32'h0);
`endif

    // dut1: no wait states, 6-cycle period.
    for (int k = 0; k < 2; k++) begin
      trace1_q.push_back(4'h1);
      trace1_q.push_back(4'h2);
      trace1_q.push_back(4'h3);
      trace1_q.push_back(4'h4);
      trace1_q.push_back(4'h8);
      trace1_q.push_back(4'h0);
    end
    per1_q.push_back(16'd6);
    per1_q.push_back(16'd6);
    rst1 = 1'b1;
    guard = 0;
    while ((trace1_q.size() != 0 || per1_q.size() != 0) && guard < 40) begin
      tick();
      guard++;
    end
    check("trace1_queue_drained", 32'(trace1_q.size()), 32'h0);
    check("period1_queue_drained", 32'(per1_q.size()), 32'h0);
    check("no_wait_codes_seen", 32'(wait_seen1), 32'h0);

    // dut2: 2-bit counter wraps.
    ret2_q.push_back(2'd1);
    ret2_q.push_back(2'd2);
    ret2_q.push_back(2'd3);
    ret2_q.push_back(2'd0);
    ret2_q.push_back(2'd1);
    rst2 = 1'b1;
    guard = 0;
    while (ret2_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("ret2_queue_drained", 32'(ret2_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
